// File: rtl/router_fsm_nch.sv
// router_fsm_nch: N-channel router control FSM with invalid-address dropping.
// Optional macro WAIT_TIMEOUT_EN adds a bounded WAIT_TILL_EMPTY with timeout_err.
module router_fsm_nch #(
  parameter int N_CH         = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [N_CH-1:0]   fifo_full,
  input  logic [N_CH-1:0]   fifo_empty,
  input  logic [N_CH-1:0]   soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [N_CH-1:0]   dest_sel,
  output logic              timeout_err
);

  typedef enum logic [3:0] {
    S_DA   = 4'd0,
    S_LFD  = 4'd1,
    S_LD   = 4'd2,
    S_LP   = 4'd3,
    S_CPE  = 4'd4,
    S_FFS  = 4'd5,
    S_LAF  = 4'd6,
    S_WTE  = 4'd7,
    S_DROP = 4'd8
  } state_t;

  if (N_CH < 2 || N_CH > 8 || (1 << ADDR_W) < N_CH
      || WAIT_TIMEOUT < 1) begin : g_bad_param
    $error("router_fsm_nch: illegal parameters");
  end

  state_t          r_state;
  state_t          w_next;
  logic [N_CH-1:0] r_dest;
  logic [N_CH-1:0] w_a_oh;
  logic            w_a_ok;
  logic            w_a_empty;
  logic            w_latch;
  logic            w_full;
  logic            w_empty;
  logic            w_srst;
  logic            w_tmo;

  // one-hot decode of the header address; out-of-range gives all zeros
  always_comb begin
    w_a_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_a_oh[i] = (32'(data_in) == i);
    end
  end

  assign w_a_ok    = |w_a_oh;
  assign w_a_empty = |(w_a_oh & fifo_empty);
  assign w_full    = |(r_dest & fifo_full);
  assign w_empty   = |(r_dest & fifo_empty);
  assign w_srst    = |(r_dest & soft_reset);

`ifdef WAIT_TIMEOUT_EN
  localparam int TW = (WAIT_TIMEOUT > 255) ? 16 : 8;
  logic [TW-1:0] r_timer;
  logic          r_tmo_err;

  assign w_tmo = (r_timer == TW'(WAIT_TIMEOUT - 1));

  // wait timer counts cycles in WAIT_TILL_EMPTY; pulse on timeout exit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer   <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_timer   <= (r_state == S_WTE) ? r_timer + TW'(1) : '0;
      r_tmo_err <= (r_state == S_WTE) && (w_next == S_DROP);
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // next-state selection; soft reset of the addressed channel overrides
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    if (r_state != S_DA && w_srst) begin
      w_next = S_DA;
    end else begin
      case (r_state)
        S_DA: begin
          if (pkt_valid) begin
            unique case (1'b1)
              !w_a_ok: w_next = S_DROP;
              w_a_ok && w_a_empty: begin
                w_next  = S_LFD;
                w_latch = 1'b1;
              end
              w_a_ok && !w_a_empty: begin
                w_next  = S_WTE;
                w_latch = 1'b1;
              end
            endcase
          end
        end
        S_WTE: begin
          if (w_empty)    w_next = S_LFD;
          else if (w_tmo) w_next = S_DROP;
        end
        S_LFD: w_next = S_LD;
        S_LD: begin
          if (w_full)          w_next = S_FFS;
          else if (!pkt_valid) w_next = S_LP;
        end
        S_LP:  w_next = S_CPE;
        S_CPE: w_next = w_full ? S_FFS : S_DA;
        S_FFS: begin
          if (!w_full) w_next = S_LAF;
        end
        S_LAF: begin
          if (parity_done)        w_next = S_DA;
          else if (low_pkt_valid) w_next = S_LP;
          else                    w_next = S_LD;
        end
        S_DROP: begin
          if (!pkt_valid) w_next = S_DA;
        end
        default: w_next = S_DA;
      endcase
    end
  end

  // state and latched destination
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_DA;
      r_dest  <= N_CH'(1);
    end else begin
      r_state <= w_next;
      if (w_latch) r_dest <= w_a_oh;
    end
  end

  // Moore output decode; illegal encodings drive everything low
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b0;
    drop_state    = 1'b0;
    dest_sel      = '0;
    case (r_state)
      S_DA: detect_add = 1'b1;
      S_WTE: begin
        busy     = 1'b1;
        dest_sel = r_dest;
      end
      S_LFD: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
        dest_sel  = r_dest;
      end
      S_LD: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        dest_sel      = r_dest;
      end
      S_LP: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
        dest_sel      = r_dest;
      end
      S_CPE: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
        dest_sel    = r_dest;
      end
      S_FFS: begin
        full_state = 1'b1;
        busy       = 1'b1;
        dest_sel   = r_dest;
      end
      S_LAF: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
        dest_sel      = r_dest;
      end
      S_DROP: drop_state = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed bench for router_fsm_nch.
// Packet-level reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_router_fsm_nch;
  localparam int N  = 3;
  localparam int AW = 2;
`ifdef WAIT_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pkt_valid = 1'b0;
  logic [AW-1:0] data_in = '0;
  logic [N-1:0]  fifo_full = '0;
  logic [N-1:0]  fifo_empty = '1;
  logic [N-1:0]  soft_reset = '0;
  logic          parity_done = 1'b0;
  logic          low_pkt_valid = 1'b0;
  logic          detect_add, lfd_state, ld_state, laf_state;
  logic          full_state, rst_int_reg, write_enb_reg, busy;
  logic          drop_state, timeout_err;
  logic [N-1:0]  dest_sel;

  int checks = 0;
  int errors = 0;

  router_fsm_nch #(.N_CH(N), .ADDR_W(AW), .WAIT_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy),
    .drop_state(drop_state), .dest_sel(dest_sel),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam int M_DA = 10, M_WT = 11, M_LFD = 12, M_LD = 13;
  localparam int M_LP = 14, M_CPE = 15, M_FF = 16, M_LAF = 17;
  localparam int M_DROP = 18;

  int m_st = M_DA;
  int m_dest = 0;
  int m_wait = 0;
  bit m_tmo = 1'b0;
  bit m_on = 1'b0;

  // packet-level reference: phase, destination number, wait count
  always @(posedge clock) begin
    if (reset) begin
      m_st   <= M_DA;
      m_dest <= 0;
      m_wait <= 0;
      m_tmo  <= 1'b0;
      m_on   <= 1'b1;
    end else begin
      m_tmo <= 1'b0;
      if (m_st != M_DA && soft_reset[m_dest]) m_st <= M_DA;
      else case (m_st)
        M_DA: if (pkt_valid) begin
          if (int'(data_in) >= N) m_st <= M_DROP;
          else begin
            m_dest <= int'(data_in);
            m_wait <= 0;
            m_st   <= fifo_empty[data_in] ? M_LFD : M_WT;
          end
        end
        M_WT: begin
          m_wait <= m_wait + 1;
          if (fifo_empty[m_dest]) m_st <= M_LFD;
`ifdef WAIT_TIMEOUT_EN
          else if (m_wait + 1 == TMO) begin
            m_st  <= M_DROP;
            m_tmo <= 1'b1;
          end
`endif
        end
        M_LFD: m_st <= M_LD;
        M_LD: begin
          if (fifo_full[m_dest]) m_st <= M_FF;
          else if (!pkt_valid)   m_st <= M_LP;
        end
        M_LP:  m_st <= M_CPE;
        M_CPE: m_st <= fifo_full[m_dest] ? M_FF : M_DA;
        M_FF:  if (!fifo_full[m_dest]) m_st <= M_LAF;
        M_LAF: begin
          if (parity_done)        m_st <= M_DA;
          else if (low_pkt_valid) m_st <= M_LP;
          else                    m_st <= M_LD;
        end
        M_DROP: if (!pkt_valid) m_st <= M_DA;
        default: m_st <= M_DA;
      endcase
    end
  end

  function automatic logic [12:0] exp_vec(int st, int d, bit t);
    logic [N-1:0] sel;
    logic [8:0]   f;
    sel = (st == M_DA || st == M_DROP) ? '0 : N'(1) << d;
    f = {st == M_DA, st == M_LFD, st == M_LD, st == M_LAF,
         st == M_FF, st == M_CPE,
         st == M_LD || st == M_LP || st == M_LAF,
         !(st == M_DA || st == M_LD || st == M_DROP),
         st == M_DROP};
    return {f, sel, t};
  endfunction

  logic [12:0] act_v;
  assign act_v = {detect_add, lfd_state, ld_state, laf_state,
                  full_state, rst_int_reg, write_enb_reg, busy,
                  drop_state, dest_sel, timeout_err};

  // every-cycle comparison against the model
  always @(negedge clock) begin
    if (m_on) begin
      checks++;
      if (act_v !== exp_vec(m_st, m_dest, m_tmo)) begin
        errors++;
        $display("FAIL model t=%0t got %b want %b", $time,
                 act_v, exp_vec(m_st, m_dest, m_tmo));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_da(input string nm);
    int k = 0;
    while (detect_add !== 1'b1 && k < 30) begin
      step(1);
      k++;
    end
    chk(nm, 32'(detect_add), 1);
  endtask

  int          we_cnt, ld_cnt, dr_cnt;
  logic [N-1:0] sel_or;

  initial begin
    step(2);
    reset = 1'b0;
    chk("reset_detect", 32'(detect_add), 1);
    chk("reset_rest", 32'(act_v[11:0]), 0);

    // normal packet to channel 2
    fifo_empty = 3'b111;
    data_in = 2'd2;
    pkt_valid = 1'b1;
    step(1);
    chk("t1_lfd", 32'(lfd_state), 1);
    chk("t1_sel", 32'(dest_sel), 32'h4);
    we_cnt = 0;
    ld_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pkt_valid = 1'b0;
      step(1);
      we_cnt += int'(write_enb_reg);
      ld_cnt += int'(ld_state);
    end
    chk("t1_we_cycles", 32'(we_cnt), 5);
    chk("t1_ld_cycles", 32'(ld_cnt), 4);
    chk("t1_back_da", 32'(detect_add), 1);

    // wait for addressed channel only
    data_in = 2'd1;
    fifo_empty = 3'b101;
    pkt_valid = 1'b1;
    step(1);
    chk("t2_wait_busy", 32'({busy, lfd_state}), 32'h2);
    chk("t2_sel", 32'(dest_sel), 32'h2);
    fifo_empty = 3'b000;
    step(1);
    fifo_empty = 3'b101;
    step(1);
    fifo_empty = 3'b100;
    step(1);
    chk("t2_hold", 32'({busy, lfd_state}), 32'h2);
    fifo_empty = 3'b010;
    step(1);
    chk("t2_lfd", 32'(lfd_state), 1);
    fifo_empty = 3'b111;
    pkt_valid = 1'b0;
    wait_da("t2_done");

    // invalid address dropped
    data_in = 2'd3;
    pkt_valid = 1'b1;
    dr_cnt = 0;
    we_cnt = 0;
    sel_or = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) pkt_valid = 1'b0;
      step(1);
      dr_cnt += int'(drop_state);
      we_cnt += int'(write_enb_reg);
      sel_or |= dest_sel;
    end
    chk("t3_drop_cycles", 32'(dr_cnt), 6);
    chk("t3_no_write", 32'(we_cnt), 0);
    chk("t3_sel_zero", 32'(sel_or), 0);
    chk("t3_back_da", 32'(detect_add), 1);

    // full handling, low_pkt_valid exit
    data_in = 2'd0;
    pkt_valid = 1'b1;
    step(2);
    chk("t4_ld", 32'(ld_state), 1);
    fifo_full = 3'b001;
    step(1);
    chk("t4_full_busy", 32'({full_state, busy}), 32'h3);
    pkt_valid = 1'b0;
    step(2);
    chk("t4_still_full", 32'(full_state), 1);
    fifo_full = 3'b000;
    step(1);
    chk("t4_laf", 32'(laf_state), 1);
    low_pkt_valid = 1'b1;
    step(1);
    chk("t4_lp", 32'({write_enb_reg, busy, ld_state}), 32'h6);
    low_pkt_valid = 1'b0;
    wait_da("t4_done");

    // full handling, parity_done exit has priority
    pkt_valid = 1'b1;
    step(2);
    fifo_full = 3'b001;
    step(1);
    fifo_full = 3'b000;
    pkt_valid = 1'b0;
    step(1);
    chk("t4b_laf", 32'(laf_state), 1);
    parity_done = 1'b1;
    low_pkt_valid = 1'b1;
    step(1);
    chk("t4b_da", 32'(detect_add), 1);
    parity_done = 1'b0;
    low_pkt_valid = 1'b0;

    // soft reset: ignored in decode and for other channels
    soft_reset = 3'b111;
    data_in = 2'd0;
    pkt_valid = 1'b1;
    step(1);
    soft_reset = 3'b010;
    chk("t5_lfd", 32'(lfd_state), 1);
    step(2);
    chk("t5_other_ign", 32'(ld_state), 1);
    soft_reset = 3'b001;
    step(1);
    chk("t5_srst_da", 32'(detect_add), 1);
    soft_reset = 3'b000;
    pkt_valid = 1'b0;
    step(1);

    // hard reset mid-packet
    data_in = 2'd2;
    pkt_valid = 1'b1;
    step(3);
    chk("t5_pre_rst", 32'(ld_state), 1);
    reset = 1'b1;
    step(1);
    chk("t5_rst_da", 32'(detect_add), 1);
    chk("t5_rst_rest", 32'(act_v[11:0]), 0);
    reset = 1'b0;
    pkt_valid = 1'b0;
    step(1);

`ifdef WAIT_TIMEOUT_EN
    // timeout while addressed channel stays non-empty
    data_in = 2'd1;
    fifo_empty = 3'b101;
    pkt_valid = 1'b1;
    step(4);
    chk("t6_wait4", 32'({busy, drop_state}), 32'h2);
    step(1);
    chk("t6_drop_pulse", 32'({drop_state, timeout_err}), 32'h3);
    step(1);
    chk("t6_pulse_end", 32'({drop_state, timeout_err}), 32'h2);
    pkt_valid = 1'b0;
    wait_da("t6_done");

    // empty on the last wait cycle wins
    pkt_valid = 1'b1;
    step(4);
    fifo_empty = 3'b111;
    step(1);
    chk("t6b_lfd", 32'({lfd_state, timeout_err}), 32'h2);
    pkt_valid = 1'b0;
    wait_da("t6b_done");
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
